alu_datapath: RTL and testbench
===============================

Name: alu_datapath

Overview:
- Register/arithmetic datapath for the 8-bit ALU (add, subtract, Booth multiply, non-restoring divide).
- Consumes the one-hot control word c[14:0] from the ALU sequencer.
- Returns the status bits the sequencer branches on (q_0, q_min1, sign, cnt7).
- Presents results on a registered output bus with a one-cycle valid strobe.

Parameters:
- WIDTH, 8, operand width; A is WIDTH+1 bits, Q and M are WIDTH bits.
- CNT_W, 3, iteration counter width; equals clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- c  input  15  control word, one-hot except c[4]&c[5].
- inbus  input  WIDTH  operand input, sampled on load cycles.
- q_0  output  1  Q[0].
- q_min1  output  1  Booth extra bit Q-1.
- sign  output  1  A[WIDTH] (accumulator sign).
- cnt7  output  1  high when cnt == WIDTH-1.
- outbus  output  2*WIDTH  registered result.
- out_valid  output  1  one-cycle pulse when outbus is updated.
- ctrl_err  output  1  one-cycle pulse on an illegal control word.

Behaviour:
- Registers: A[WIDTH:0], Q[WIDTH-1:0], Qm1, M[WIDTH-1:0], cnt[CNT_W-1:0], outbus, out_valid, ctrl_err.
- rst asserted at any time, including mid-operation: all registers are 0 asynchronously. Consequently q_0=q_min1=sign=cnt7=0, outbus=0, out_valid=0.
- Status outputs are combinational from registers, so a change is visible in the same cycle as the register update.
- All operations below take effect on the rising edge where the bit is high.
- c[0] (add/sub init): A <= sign-extended inbus; Q, Qm1, cnt <= 0.
- c[1] (mul init): A <= 0; Q <= inbus; Qm1 <= 0; cnt <= 0.
- c[2] (div init): A <= 0; Q <= inbus; cnt <= 0.
- c[3]: M <= inbus.
- c[4]: A <= A + Msx, or A - Msx when c[5]=1. Msx is M sign-extended to WIDTH+1. Arithmetic is modulo 2^(WIDTH+1) with no overflow flag.
- c[5] without c[4]: no operation.
- c[6]: Q[0] <= ~A[WIDTH].
- c[7]: cnt <= cnt+1 (divide loop).
- c[8]: arithmetic shift right of {A,Q,Qm1}. A[WIDTH] is kept; Qm1 <= Q[0].
- c[9]: shift left of {A,Q}. Q[0] <= 0; A[WIDTH] <= old A[WIDTH-1].
- c[10]: cnt <= cnt+1 (multiply loop).
- c[11] (remainder correction): A <= A + Msx.
- c[12]: outbus <= {0, A[WIDTH-1:0]}.
- c[13]: outbus <= {A[WIDTH-1:0], Q}.
- c[14]: outbus <= {0, Q}.
- out_valid is 1 in the cycle after any of c[12..14] is sampled, otherwise 0.
- Counter wraps from 2^CNT_W-1 to 0 with no saturation.
- c = 0: all registers hold; out_valid = 0.
- Illegal word (more than one bit set, excluding the pair c[4]&c[5]):
  - ctrl_err pulses for one cycle.
  - Only the lowest-indexed set bit is executed; c[4]&c[5] counts as one bit at index 4.
- Latency: one cycle from control bit to register update and to status change.
- Single clock domain.

Decomposition:
- Package alu_pkg holds:
  - WIDTH and CNT_W defaults.
  - Control-bit index localparams: C_LD_ADD=0, C_LD_MUL=1, C_LD_DIV=2, C_LD_M=3, C_ARITH=4, C_SUB=5, C_SETQ0=6, C_CNT_DIV=7, C_ASR=8, C_LSH=9, C_CNT_MUL=10, C_COR=11, C_OUT_A=12, C_OUT_AQ=13, C_OUT_Q=14.
- The sequencer and datapath share this package.
- One sub-module: alu_addsub, a combinational (WIDTH+1)-bit adder with a subtract input. It is used by both c[4] and c[11].

Test Plan:
- Reset mid-operation: load Q=0xA5 with c[1], then assert rst -> all status bits 0, outbus=0x0000, out_valid=0.
- Add/subtract:
  - c[0] with inbus=0x05, then c[3] with 0x03, then c[4] -> A=0x008, sign=0.
  - Same operands, then c[4]|c[5] -> A=0x002.
  - c[12] -> outbus=0x0002 with out_valid pulse; c[13] and c[14] follow their field definitions.
- Multiply 3×(-2):
  - Drive the Booth sequence by hand: c[1] with Q=0x03, c[3] with M=0xFE, then c[4]/c[5]/c[8]/c[10] per Q[0]:Qm1, eight iterations.
  - Required: cnt7 rises after seven c[10] pulses; c[13] -> outbus=0xFFFA.
- Shift and set: A=0x080, Q=0x01; c[9] -> A=0x100, Q=0x02, sign=1; then c[6] -> Q[0]=0.
- Divide step/correction: c[2] with Q=0x07, c[3] with M=0x02, c[4]|c[5] -> A=0x1FE, sign=1; c[11] -> A=0x000.
- Illegal word: c=0x0300 (bits 8 and 9) -> only ASR executes, ctrl_err pulses one cycle; c=0x0030 -> subtract executes with no ctrl_err.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, control-bit indices and control decode for the ALU
package alu_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 3;
  localparam int NUM_CTRL  = 15;

  localparam int C_LD_ADD  = 0;
  localparam int C_LD_MUL  = 1;
  localparam int C_LD_DIV  = 2;
  localparam int C_LD_M    = 3;
  localparam int C_ARITH   = 4;
  localparam int C_SUB     = 5;
  localparam int C_SETQ0   = 6;
  localparam int C_CNT_DIV = 7;
  localparam int C_ASR     = 8;
  localparam int C_LSH     = 9;
  localparam int C_CNT_MUL = 10;
  localparam int C_COR     = 11;
  localparam int C_OUT_A   = 12;
  localparam int C_OUT_AQ  = 13;
  localparam int C_OUT_Q   = 14;

  typedef struct packed {
    logic [NUM_CTRL-1:0] sel;
    logic                illegal;
    logic                sub;
  } ctrl_dec_t;

  // The c[4]&c[5] pair is one operation, so c[5] is folded away before
  // isolating the lowest set bit and counting the rest.
  function automatic ctrl_dec_t decode_ctrl(input logic [NUM_CTRL-1:0] c);
    ctrl_dec_t           d;
    logic [NUM_CTRL-1:0] eff;
    eff = c;
    if (c[C_ARITH]) eff[C_SUB] = 1'b0;
    d.sel     = eff & (~eff + NUM_CTRL'(1));
    d.illegal = (eff & (eff - NUM_CTRL'(1))) != '0;
    d.sub     = d.sel[C_ARITH] & c[C_SUB];
    return d;
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// rtl/alu_addsub.sv - combinational adder/subtractor shared by the add and correction steps
module alu_addsub #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum
);

  assign sum = a + (b ^ {N{sub}}) + {{(N-1){1'b0}}, sub};

endmodule

// File: rtl/alu_datapath.sv
// rtl/alu_datapath.sv - A/Q/M register datapath for add, sub, Booth multiply and divide
module alu_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CTRL-1:0]  c,
  input  logic [WIDTH-1:0]     inbus,
  output logic                 q_0,
  output logic                 q_min1,
  output logic                 sign,
  output logic                 cnt7,
  output logic [2*WIDTH-1:0]   outbus,
  output logic                 out_valid,
  output logic                 ctrl_err
);

  logic [WIDTH:0]   a;
  logic [WIDTH-1:0] q;
  logic             qm1;
  logic [WIDTH-1:0] m;
  logic [CNT_W-1:0] cnt;

  ctrl_dec_t      dec;
  logic [WIDTH:0] msx;
  logic [WIDTH:0] sum;

  assign dec = decode_ctrl(c);
  assign msx = {m[WIDTH-1], m};

  alu_addsub #(.N(WIDTH+1)) u_addsub (
    .a   (a),
    .b   (msx),
    .sub (dec.sub),
    .sum (sum)
  );

  assign q_0    = q[0];
  assign q_min1 = qm1;
  assign sign   = a[WIDTH];
  assign cnt7   = (cnt == CNT_W'(WIDTH-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a         <= '0;
      q         <= '0;
      qm1       <= 1'b0;
      m         <= '0;
      cnt       <= '0;
      outbus    <= '0;
      out_valid <= 1'b0;
      ctrl_err  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      ctrl_err  <= dec.illegal;
      if (dec.sel[C_LD_ADD]) begin
        a   <= {inbus[WIDTH-1], inbus};
        q   <= '0;
        qm1 <= 1'b0;
        cnt <= '0;
      end else if (dec.sel[C_LD_MUL]) begin
        a   <= '0;
        q   <= inbus;
        qm1 <= 1'b0;
        cnt <= '0;
      end else if (dec.sel[C_LD_DIV]) begin
        a   <= '0;
        q   <= inbus;
        cnt <= '0;
      end else if (dec.sel[C_LD_M]) begin
        m <= inbus;
      end else if (dec.sel[C_ARITH] || dec.sel[C_COR]) begin
        a <= sum;
      end else if (dec.sel[C_SUB]) begin
        // a lone subtract qualifier has nothing to qualify
      end else if (dec.sel[C_SETQ0]) begin
        q <= {q[WIDTH-1:1], ~a[WIDTH]};
      end else if (dec.sel[C_CNT_DIV] || dec.sel[C_CNT_MUL]) begin
        cnt <= cnt + CNT_W'(1);
      end else if (dec.sel[C_ASR]) begin
        a   <= {a[WIDTH], a[WIDTH:1]};
        q   <= {a[0], q[WIDTH-1:1]};
        qm1 <= q[0];
      end else if (dec.sel[C_LSH]) begin
        a <= {a[WIDTH-1:0], q[WIDTH-1]};
        q <= {q[WIDTH-2:0], 1'b0};
      end else if (dec.sel[C_OUT_A]) begin
        outbus    <= {{WIDTH{1'b0}}, a[WIDTH-1:0]};
        out_valid <= 1'b1;
      end else if (dec.sel[C_OUT_AQ]) begin
        outbus    <= {a[WIDTH-1:0], q};
        out_valid <= 1'b1;
      end else if (dec.sel[C_OUT_Q]) begin
        outbus    <= {{WIDTH{1'b0}}, q};
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_datapath.sv
// tb/tb_alu_datapath.sv - directed and randomized checks of alu_datapath against an arithmetic model
module tb_alu_datapath;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] c;
  logic [7:0]  inbus;
  logic        q_0, q_min1, sign, cnt7, out_valid, ctrl_err;
  logic [15:0] outbus;

  int passed = 0;
  int total  = 0;

  // reference state held as plain integers
  int m_a, m_q, m_qm1, m_m, m_cnt, m_ob, m_ov, m_ce;

  alu_datapath dut (
    .clk       (clk),
    .rst       (rst),
    .c         (c),
    .inbus     (inbus),
    .q_0       (q_0),
    .q_min1    (q_min1),
    .sign      (sign),
    .cnt7      (cnt7),
    .outbus    (outbus),
    .out_valid (out_valid),
    .ctrl_err  (ctrl_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_a = 0; m_q = 0; m_qm1 = 0; m_m = 0; m_cnt = 0; m_ob = 0; m_ov = 0; m_ce = 0;
  endtask

  function automatic int sx9(input int v);
    return (v >= 128) ? v + 256 : v;
  endfunction

  task automatic model_step(input logic [14:0] cw, input int ib);
    int low, n, full;
    low = -1;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      if (cw[i] && !(i == 5 && cw[4])) begin
        n++;
        if (low < 0) low = i;
      end
    end
    m_ce = (n > 1) ? 1 : 0;
    m_ov = 0;
    case (low)
      0: begin m_a = sx9(ib); m_q = 0; m_qm1 = 0; m_cnt = 0; end
      1: begin m_a = 0; m_q = ib; m_qm1 = 0; m_cnt = 0; end
      2: begin m_a = 0; m_q = ib; m_cnt = 0; end
      3: m_m = ib;
      4: m_a = cw[5] ? (m_a + 512 - sx9(m_m)) % 512 : (m_a + sx9(m_m)) % 512;
      6: m_q = (m_q / 2) * 2 + ((m_a >= 256) ? 0 : 1);
      7, 10: m_cnt = (m_cnt + 1) % 8;
      8: begin
        full = m_a * 512 + m_q * 2 + m_qm1;
        full = full / 2 + ((m_a >= 256) ? (1 << 17) : 0);
        m_a = full / 512;
        m_q = (full / 2) % 256;
        m_qm1 = full % 2;
      end
      9: begin
        full = ((m_a * 256 + m_q) * 2) % (1 << 17);
        m_a = full / 256;
        m_q = full % 256;
      end
      11: m_a = (m_a + sx9(m_m)) % 512;
      12: begin m_ob = m_a % 256; m_ov = 1; end
      13: begin m_ob = (m_a % 256) * 256 + m_q; m_ov = 1; end
      14: begin m_ob = m_q; m_ov = 1; end
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q_0"},       q_0,       m_q % 2);
    chk({tag, ".q_min1"},    q_min1,    m_qm1);
    chk({tag, ".sign"},      sign,      (m_a >= 256) ? 1 : 0);
    chk({tag, ".cnt7"},      cnt7,      (m_cnt == 7) ? 1 : 0);
    chk({tag, ".outbus"},    outbus,    m_ob);
    chk({tag, ".out_valid"}, out_valid, m_ov);
    chk({tag, ".ctrl_err"},  ctrl_err,  m_ce);
  endtask

  task automatic step(input string tag, input logic [14:0] cw, input logic [7:0] ib);
    c = cw;
    inbus = ib;
    @(posedge clk);
    #1;
    model_step(cw, int'(ib));
    check_all(tag);
  endtask

  task automatic booth(input logic [7:0] x, input logic [7:0] y);
    int p;
    step("b_ldq", 15'h0002, x);
    step("b_ldm", 15'h0008, y);
    for (int i = 0; i < 8; i++) begin
      if ((m_q % 2) == 1 && m_qm1 == 0) step("b_sub", 15'h0030, 8'h00);
      else if ((m_q % 2) == 0 && m_qm1 == 1) step("b_add", 15'h0010, 8'h00);
      step("b_asr", 15'h0100, 8'h00);
      step("b_cnt", 15'h0400, 8'h00);
      if (i == 5) chk("booth_cnt7_after6", cnt7, 1'b0);
      if (i == 6) chk("booth_cnt7_after7", cnt7, 1'b1);
      if (i == 7) chk("booth_cnt_wrap", cnt7, 1'b0);
    end
    step("b_out", 15'h2000, 8'h00);
    p = $signed(x) * $signed(y);
    chk("booth_product", outbus, p & 16'hFFFF);
  endtask

  initial begin
    logic [14:0] cw;
    rst = 1'b1;
    c = '0;
    inbus = '0;
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b0;

    // reset mid-operation
    step("mid_ldmul", 15'h0002, 8'hA5);
    chk("mid_q0", q_0, 1'b1);
    step("mid_outq", 15'h4000, 8'h00);
    chk("mid_outbus", outbus, 16'h00A5);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("mid_rst");
    chk("mid_rst_outbus", outbus, 16'h0000);
    rst = 1'b0;

    // add then subtract
    step("add_ld", 15'h0001, 8'h05);
    step("add_m", 15'h0008, 8'h03);
    step("add_op", 15'h0010, 8'h00);
    chk("add_sign", sign, 1'b0);
    step("add_out", 15'h1000, 8'h00);
    chk("add_outbus", outbus, 16'h0008);
    chk("add_valid", out_valid, 1'b1);
    step("idle", 15'h0000, 8'h00);
    chk("idle_valid", out_valid, 1'b0);
    step("sub_ld", 15'h0001, 8'h05);
    step("sub_m", 15'h0008, 8'h03);
    step("sub_op", 15'h0030, 8'h00);
    chk("sub_no_err", ctrl_err, 1'b0);
    step("sub_out", 15'h1000, 8'h00);
    chk("sub_outbus", outbus, 16'h0002);
    step("sub_outaq", 15'h2000, 8'h00);
    chk("sub_outaq_bus", outbus, 16'h0200);
    step("sub_outq", 15'h4000, 8'h00);
    chk("sub_outq_bus", outbus, 16'h0000);

    booth(8'h03, 8'hFE);
    chk("booth_3x-2", outbus, 16'hFFFA);

    // shift left then set Q[0]
    step("sh_ldq", 15'h0002, 8'h01);
    step("sh_m", 15'h0008, 8'h40);
    step("sh_add1", 15'h0010, 8'h00);
    step("sh_add2", 15'h0010, 8'h00);
    step("sh_lsh", 15'h0200, 8'h00);
    chk("sh_sign", sign, 1'b1);
    chk("sh_q0", q_0, 1'b0);
    step("sh_outaq", 15'h2000, 8'h00);
    chk("sh_outaq_bus", outbus, 16'h0002);
    step("sh_setq", 15'h0040, 8'h00);
    chk("sh_setq_q0", q_0, 1'b0);

    // divide step and correction
    step("dv_ld", 15'h0004, 8'h07);
    step("dv_m", 15'h0008, 8'h02);
    step("dv_sub", 15'h0030, 8'h00);
    chk("dv_sign", sign, 1'b1);
    step("dv_outa", 15'h1000, 8'h00);
    chk("dv_outa_bus", outbus, 16'h00FE);
    step("dv_cor", 15'h0800, 8'h00);
    chk("dv_cor_sign", sign, 1'b0);
    step("dv_outa2", 15'h1000, 8'h00);
    chk("dv_cor_bus", outbus, 16'h0000);

    // illegal word: lowest bit wins
    step("il_ldq", 15'h0002, 8'h03);
    step("il_asr_lsh", 15'h0300, 8'h00);
    chk("il_err", ctrl_err, 1'b1);
    chk("il_qm1", q_min1, 1'b1);
    step("il_idle", 15'h0000, 8'h00);
    chk("il_err_clear", ctrl_err, 1'b0);
    step("il_pair", 15'h0030, 8'h00);
    chk("il_pair_no_err", ctrl_err, 1'b0);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: cw = 15'(1) << $urandom_range(0, 14);
        6:                cw = 15'h0030;
        default:          cw = 15'($urandom_range(0, 32767));
      endcase
      step("rnd", cw, 8'($urandom_range(0, 255)));
    end

    for (int i = 0; i < 6; i++) begin
      booth(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
